tx_pcs_encoder: RTL and testbench
=================================

TX_PCS_ENCODER -- requirements
Module: tx_pcs_encoder

Interface
REQ-001 Parameter XGMII_DATA_WIDTH, default 32, XGMII word width; only 32 is supported.
REQ-002 Parameter XGMII_CTRL_WIDTH, default 4, one control bit per XGMII byte.
REQ-003 Parameter PAUSE_PERIOD, default 66, gearbox pause period in cycles.
REQ-004 i_clk  in  1  sole clock.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_xgmii_txd  in  32  XGMII data word; lane 0 is bits [7:0].
REQ-007 i_xgmii_ctrl  in  4  per-lane control flag; 1 means control character.
REQ-008 i_xgmii_valid  in  1  word qualifier; the word is consumed only when this is 1.
REQ-009 o_xgmii_pause  out  1  upstream stall request for the gearbox slip.
REQ-010 o_block_data  out  64  66b block payload; block-type byte is bits [7:0].
REQ-011 o_block_hdr  out  2  sync header: 2'b01 for data, 2'b10 for control.
REQ-012 o_block_valid  out  1  one-cycle strobe qualifying o_block_data and o_block_hdr.

Function
REQ-013 Phase bit toggles on each valid word; phase 0 word is stored as lanes 0-3, phase 1 word completes lanes 4-7.
REQ-014 Words with i_xgmii_valid=0 are ignored; phase and stored half-block are held.
REQ-015 Block is registered: o_block_valid=1 exactly one cycle after the phase-1 word is accepted, otherwise 0.
REQ-016 All 8 ctrl bits 0 -> hdr 01, payload equals the 8 data bytes unchanged.
REQ-017 All lanes control, each IDLE 0x07 or ERROR 0xFE -> type 0x1E, 7-bit codes at bits 8+7i (IDLE=0x00, ERROR=0x1E).
REQ-018 Lane 0 = START 0xFB, lanes 1-7 data -> type 0x78, lanes 1-7 copied to bytes 1-7.
REQ-019 Lanes 0-3 IDLE, lane 4 START, lanes 5-7 data -> type 0x33; codes 0x00 at bits 8-35; bits 36-39 = 0; data in bytes 5-7.
REQ-020 TERMINATE 0xFD in lane k (0-7), lanes <k data, lanes >k IDLE -> type 0x87/99/AA/B4/CC/D2/E1/FF for k=0..7.
REQ-021 Terminate packing: data bytes in bytes 1..k; 7-bit 0x00 codes fill the top 7*(7-k) bits ending at bit 63; gap bits are 0.
REQ-022 Any other lane pattern, including unknown control characters, -> type 0x1E with all eight codes 0x1E (error block), hdr 10.
REQ-023 Pause counter runs 0..PAUSE_PERIOD-1 every cycle and wraps to 0.
REQ-024 o_xgmii_pause=1 while the pause counter is PAUSE_PERIOD-2 or PAUSE_PERIOD-1, i.e. 2 of every 66 cycles.
REQ-025 Valid words arriving while pause=1 are still encoded; the upstream is responsible for honouring the pause.
REQ-026 Simultaneous reset and valid word: reset wins and the word is dropped.

Reset
REQ-027 While reset is asserted: o_block_data=0, o_block_hdr=2'b00, o_block_valid=0, o_xgmii_pause=0.
REQ-028 While reset is asserted: phase=0, pause counter=0, stored half-block cleared.
REQ-029 Reset mid-block discards the stored phase-0 half; the first valid word after reset is phase 0.

Structure
REQ-030 Shared package eth_pkg holds XGMII characters (0x07, 0xFB, 0xFD, 0xFE), 7-bit control codes, block-type constants, and sync-header constants.
REQ-031 Single module; block classification and packing are one combinational function in eth_pkg; no sub-module.

Verification
REQ-032 Idle: two words 0x07070707, ctrl F -> one block, hdr 10, type 0x1E, bits 63:8 = 0.
REQ-033 Start: 0x555555FB ctrl 1, then 0xD5555555 ctrl 0 -> hdr 10, data 0xD5555555_555555_78.
REQ-034 Terminate sweep: for k=0..7, T in lane k, data 0x11.. below, IDLE above -> correct type byte and packing per REQ-020/021.
REQ-035 Bad pattern: data in lane 1 after T in lane 0 -> error block, hdr 10, all eight codes 0x1E.
REQ-036 Gaps and pause: valid deasserted between halves -> same block; o_xgmii_pause high on cycles 64-65 of every 66 after reset.
REQ-037 Reset after a phase-0 word -> no block output; next two valid words form a fresh block.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared 10GBASE-R PCS constants plus the 64b/66b block classifier and packer.
package eth_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [7:0] BT_CTRL   = 8'h1E;
    localparam logic [7:0] BT_START0 = 8'h78;
    localparam logic [7:0] BT_START4 = 8'h33;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } block_t;

    function automatic logic [7:0] term_type(input int k);
        logic [7:0] t;
        case (k)
            0:       t = 8'h87;
            1:       t = 8'h99;
            2:       t = 8'hAA;
            3:       t = 8'hB4;
            4:       t = 8'hCC;
            5:       t = 8'hD2;
            6:       t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    function automatic block_t encode_block(input logic [63:0] d, input logic [7:0] c);
        block_t blk;
        logic   all_ie;
        logic   idle_hi;
        logic   hit;
        blk.hdr  = SH_CTRL;
        blk.data = '0;
        hit      = 1'b0;

        all_ie = (c == 8'hFF);
        for (int i = 0; i < 8; i++)
            if (d[8*i +: 8] != XGMII_IDLE && d[8*i +: 8] != XGMII_ERROR)
                all_ie = 1'b0;

        if (c == 8'h00) begin
            blk.hdr  = SH_DATA;
            blk.data = d;
            hit      = 1'b1;
        end else if (all_ie) begin
            blk.data[7:0] = BT_CTRL;
            for (int i = 0; i < 8; i++)
                blk.data[8+7*i +: 7] = (d[8*i +: 8] == XGMII_ERROR) ? CODE_ERROR : CODE_IDLE;
            hit = 1'b1;
        end else if (c == 8'h01 && d[7:0] == XGMII_START) begin
            blk.data = {d[63:8], BT_START0};
            hit      = 1'b1;
        end else if (c == 8'h1F && d[39:0] == {XGMII_START, {4{XGMII_IDLE}}}) begin
            blk.data = {d[63:40], 32'h0, BT_START4};
            hit      = 1'b1;
        end else begin
            // Trailing idle codes are all-zero, so only type and data bytes need writing.
            for (int k = 0; k < 8; k++) begin
                idle_hi = 1'b1;
                for (int j = 0; j < 8; j++)
                    if (j > k && d[8*j +: 8] != XGMII_IDLE)
                        idle_hi = 1'b0;
                if (!hit && c == (8'hFF << k) && d[8*k +: 8] == XGMII_TERM && idle_hi) begin
                    blk.data[7:0] = term_type(k);
                    for (int j = 0; j < 7; j++)
                        if (j < k)
                            blk.data[8+8*j +: 8] = d[8*j +: 8];
                    hit = 1'b1;
                end
            end
        end

        if (!hit)
            blk.data = {{8{CODE_ERROR}}, BT_CTRL};
        return blk;
    endfunction

endpackage

// File: rtl/tx_pcs_encoder.sv
// XGMII 32-bit to 64b/66b block encoder with a free-running gearbox pause generator.
module tx_pcs_encoder
    import eth_pkg::*;
#(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_CTRL_WIDTH = 4,
    parameter int PAUSE_PERIOD     = 66
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_txd,
    input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
    input  logic                        i_xgmii_valid,
    output logic                        o_xgmii_pause,
    output logic [63:0]                 o_block_data,
    output logic [1:0]                  o_block_hdr,
    output logic                        o_block_valid
);

    localparam int                CNT_W     = $clog2(PAUSE_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PAUSE_PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_PAUSE = CNT_W'(PAUSE_PERIOD - 2);

    logic                        phase_q, phase_d;
    logic [XGMII_DATA_WIDTH-1:0] half_data_q, half_data_d;
    logic [XGMII_CTRL_WIDTH-1:0] half_ctrl_q, half_ctrl_d;
    logic [CNT_W-1:0]            pause_cnt_q, pause_cnt_d;
    block_t                      blk_q, blk_d;
    logic                        blk_valid_q, blk_valid_d;
    block_t                      enc;

    always_comb begin
        enc         = encode_block({i_xgmii_txd, half_data_q}, {i_xgmii_ctrl, half_ctrl_q});
        phase_d     = phase_q;
        half_data_d = half_data_q;
        half_ctrl_d = half_ctrl_q;
        blk_d       = blk_q;
        blk_valid_d = 1'b0;
        pause_cnt_d = (pause_cnt_q == CNT_LAST) ? '0 : pause_cnt_q + 1'b1;
        if (i_xgmii_valid) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                half_data_d = i_xgmii_txd;
                half_ctrl_d = i_xgmii_ctrl;
            end else begin
                blk_d       = enc;
                blk_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q     <= 1'b0;
            half_data_q <= '0;
            half_ctrl_q <= '0;
            pause_cnt_q <= '0;
            blk_q       <= '0;
            blk_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            half_data_q <= half_data_d;
            half_ctrl_q <= half_ctrl_d;
            pause_cnt_q <= pause_cnt_d;
            blk_q       <= blk_d;
            blk_valid_q <= blk_valid_d;
        end
    end

    // Gated by reset so the stall request drops immediately, not one cycle later.
    assign o_xgmii_pause = ~i_reset & (pause_cnt_q >= CNT_PAUSE);
    assign o_block_data  = blk_q.data;
    assign o_block_hdr   = blk_q.hdr;
    assign o_block_valid = blk_valid_q;

endmodule

// File: tb/tb_tx_pcs_encoder.sv
// Self-checking bench: fixed vector table, hand sequences and randomized blocks vs a byte-level model.
module tb_tx_pcs_encoder;

    localparam int PP = 66;
    localparam logic [7:0]  TT [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    localparam logic [63:0] ERR_BLK = 64'h3C78F1E3C78F1E1E;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_xgmii_txd;
    logic [3:0]  i_xgmii_ctrl;
    logic        i_xgmii_valid;
    logic        o_xgmii_pause;
    logic [63:0] o_block_data;
    logic [1:0]  o_block_hdr;
    logic        o_block_valid;

    tx_pcs_encoder #(.XGMII_DATA_WIDTH(32), .XGMII_CTRL_WIDTH(4), .PAUSE_PERIOD(PP)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_xgmii_txd(i_xgmii_txd), .i_xgmii_ctrl(i_xgmii_ctrl), .i_xgmii_valid(i_xgmii_valid),
        .o_xgmii_pause(o_xgmii_pause), .o_block_data(o_block_data),
        .o_block_hdr(o_block_hdr), .o_block_valid(o_block_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_phase;
    logic [31:0] m_lo;
    logic [3:0]  m_lo_c;
    int          m_cnt;
    logic [1:0]  m_hdr;
    logic [63:0] m_data;

    typedef struct {
        string       name;
        logic [31:0] w0;
        logic [3:0]  c0;
        logic [31:0] w1;
        logic [3:0]  c1;
        logic [1:0]  hdr;
        logic [63:0] data;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference: lanes as bytes, rules applied directly from the block-format definitions.
    function automatic void ref_enc(input logic [63:0] d, input logic [7:0] c,
                                    output logic [1:0] hdr, output logic [63:0] blk);
        logic [7:0] b [8];
        bit all_ie, is_term;
        int t;
        for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
        hdr = 2'b10;
        if (c == 8'h00) begin
            hdr = 2'b01;
            blk = d;
            return;
        end
        all_ie = 1;
        for (int i = 0; i < 8; i++)
            if (!c[i] || (b[i] != 8'h07 && b[i] != 8'hFE)) all_ie = 0;
        if (all_ie) begin
            blk = 64'h1E;
            for (int i = 0; i < 8; i++)
                if (b[i] == 8'hFE) blk = blk | (64'h1E << (8 + 7*i));
            return;
        end
        if (c == 8'h01 && b[0] == 8'hFB) begin
            blk = (d & ~64'hFF) | 64'h78;
            return;
        end
        if (c == 8'h1F && b[0] == 8'h07 && b[1] == 8'h07 && b[2] == 8'h07 && b[3] == 8'h07 && b[4] == 8'hFB) begin
            blk = ((d >> 40) << 40) | 64'h33;
            return;
        end
        t = 0;
        while (!c[t]) t++;
        is_term = (b[t] == 8'hFD);
        for (int i = 0; i < 8; i++) begin
            if (c[i] != (i >= t)) is_term = 0;
            if (i > t && b[i] != 8'h07) is_term = 0;
        end
        if (is_term) begin
            blk = ((d & ((64'h1 << (8*t)) - 64'h1)) << 8) | 64'(TT[t]);
            return;
        end
        blk = 64'h1E;
        for (int i = 0; i < 8; i++) blk = blk | (64'h1E << (8 + 7*i));
    endfunction

    task automatic step(input logic rst, input logic v, input logic [31:0] w, input logic [3:0] c);
        logic exp_v;
        i_reset = rst; i_xgmii_valid = v; i_xgmii_txd = w; i_xgmii_ctrl = c;
        @(posedge i_clk);
        #1;
        exp_v = 1'b0;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_hdr = 2'b00; m_data = '0; m_lo = '0; m_lo_c = '0;
        end else begin
            m_cnt = (m_cnt + 1) % PP;
            if (v) begin
                if (!m_phase) begin
                    m_lo = w; m_lo_c = c; m_phase = 1;
                end else begin
                    ref_enc({w, m_lo}, {c, m_lo_c}, m_hdr, m_data);
                    exp_v = 1'b1; m_phase = 0;
                end
            end
        end
        chk("blk_valid", 64'(o_block_valid), 64'(exp_v));
        chk("pause", 64'(o_xgmii_pause), 64'(!rst && m_cnt >= PP - 2));
        if (rst || exp_v) begin
            chk("blk_hdr", 64'(o_block_hdr), 64'(m_hdr));
            chk("blk_data", o_block_data, m_data);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] c, input int maxgap);
        int g;
        step(1'b0, 1'b1, d[31:0], c[3:0]);
        g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        for (int i = 0; i < g; i++) step(1'b0, 1'b0, $urandom, 4'($urandom));
        step(1'b0, 1'b1, d[63:32], c[7:4]);
    endtask

    initial begin
        vec_t        tbl [11];
        logic [63:0] d;
        logic [7:0]  c;
        int          k, kind;

        tbl[0]  = '{"idle",    32'h07070707, 4'hF, 32'h07070707, 4'hF, 2'b10, 64'h000000000000001E};
        tbl[1]  = '{"start0",  32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 2'b10, 64'hD555555555555578};
        tbl[2]  = '{"data",    32'h03020100, 4'h0, 32'h07060504, 4'h0, 2'b01, 64'h0706050403020100};
        tbl[3]  = '{"term0",   32'h070707FD, 4'hF, 32'h07070707, 4'hF, 2'b10, 64'h0000000000000087};
        tbl[4]  = '{"term3",   32'hFD332211, 4'h8, 32'h07070707, 4'hF, 2'b10, 64'h00000000332211B4};
        tbl[5]  = '{"term4",   32'h44332211, 4'h0, 32'h070707FD, 4'hF, 2'b10, 64'h00000044332211CC};
        tbl[6]  = '{"term7",   32'h44332211, 4'h0, 32'hFD776655, 4'h8, 2'b10, 64'h77665544332211FF};
        tbl[7]  = '{"bad_t0",  32'h070755FD, 4'hD, 32'h07070707, 4'hF, 2'b10, ERR_BLK};
        tbl[8]  = '{"err_l0",  32'h070707FE, 4'hF, 32'h07070707, 4'hF, 2'b10, 64'h0000000000001E1E};
        tbl[9]  = '{"start4",  32'h07070707, 4'hF, 32'hDDCCBBFB, 4'h1, 2'b10, 64'hDDCCBB0000000033};
        tbl[10] = '{"unk_ctl", 32'h0707079C, 4'hF, 32'h07070707, 4'hF, 2'b10, ERR_BLK};

        step(1'b1, 1'b0, 32'h0, 4'h0);
        step(1'b1, 1'b1, 32'hDEADBEEF, 4'h3);

        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].w0, tbl[i].c0);
            step(1'b0, 1'b1, tbl[i].w1, tbl[i].c1);
            chk({tbl[i].name, "_hdr"}, 64'(o_block_hdr), 64'(tbl[i].hdr));
            chk({tbl[i].name, "_data"}, o_block_data, tbl[i].data);
        end

        // terminate sweep
        for (int kk = 0; kk < 8; kk++) begin
            for (int i = 0; i < 8; i++)
                d[8*i +: 8] = (i < kk) ? 8'(8'h11 * (i + 1)) : (i == kk) ? 8'hFD : 8'h07;
            c = 8'hFF << kk;
            send(d, c, 0);
            chk("term_type", 64'(o_block_data[7:0]), 64'(TT[kk]));
        end

        // gap between halves yields the same block
        step(1'b0, 1'b1, 32'h555555FB, 4'h1);
        step(1'b0, 1'b0, 32'h12345678, 4'h0);
        step(1'b0, 1'b0, 32'h9ABCDEF0, 4'hF);
        step(1'b0, 1'b1, 32'hD5555555, 4'h0);
        chk("gap_data", o_block_data, 64'hD555555555555578);

        // reset after a phase-0 word discards it
        step(1'b0, 1'b1, 32'hAAAAAAAA, 4'h0);
        step(1'b1, 1'b0, 32'h0, 4'h0);
        step(1'b0, 1'b1, 32'h03020100, 4'h0);
        chk("rst_mid_novalid", 64'(o_block_valid), 64'd0);
        step(1'b0, 1'b1, 32'h07060504, 4'h0);
        chk("rst_mid_data", o_block_data, 64'h0706050403020100);

        // reset coinciding with the phase-1 word drops it
        step(1'b0, 1'b1, 32'h11111111, 4'h0);
        step(1'b1, 1'b1, 32'h22222222, 4'h0);
        chk("rst_win_valid", 64'(o_block_valid), 64'd0);
        step(1'b0, 1'b1, 32'h07070707, 4'hF);
        step(1'b0, 1'b1, 32'h07070707, 4'hF);
        chk("rst_win_idle", o_block_data, 64'h1E);

        // randomized blocks with gaps; long enough to see several pause windows
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 5);
            d = {$urandom, $urandom};
            c = 8'h00;
            case (kind)
                1: begin
                    c = 8'hFF;
                    for (int i = 0; i < 8; i++) d[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'h07;
                end
                2: begin
                    k = $urandom_range(0, 7);
                    c = 8'hFF << k;
                    for (int i = k; i < 8; i++) d[8*i +: 8] = (i == k) ? 8'hFD : 8'h07;
                    if ($urandom_range(0, 7) == 0) d[63:56] = 8'h55;
                end
                3: begin c = 8'h01; d[7:0] = 8'hFB; end
                4: begin c = 8'h1F; d[39:0] = 40'hFB07070707; end
                5: c = 8'($urandom);
                default: ;
            endcase
            send(d, c, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
